sram_pingpong_ctrl: RTL and testbench



---
 rtl/sram_pp_pkg.sv | 24 ++
 rtl/sram_pp_skid_fifo.sv | 50 +++++
 rtl/sram_pingpong_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sram_pingpong_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pp_pkg.sv
// Shared types and constants for the ping-pong SRAM controller.
package sram_pp_pkg;

    localparam int unsigned SRAM_AW = 8;
    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned PTR_W   = SRAM_AW - 1;
    localparam int unsigned HALF    = 2 ** PTR_W;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Block length as used by the banks: 0 and anything above HALF mean HALF.
    function automatic logic [SRAM_AW-1:0] clamp_len(input logic [SRAM_AW-1:0] len);
        if (len == '0 || len > SRAM_AW'(HALF)) begin
            return SRAM_AW'(HALF);
        end
        return len;
    endfunction

endpackage

// File: rtl/sram_pp_skid_fifo.sv
// Two-entry {last, data} skid FIFO that catches SRAM read data so the
// consumer can stall without dropping words already in flight.
module sram_pp_skid_fifo #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH:0] mem_q [2];
    logic                wr_idx_q;
    logic                rd_idx_q;
    logic [1:0]          cnt_q;

    // Storage, pointers and occupancy; the issuer guarantees no push into a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q] <= {push_last, push_data};
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head entry is presented directly.
    always_comb begin
        cnt       = cnt_q;
        head_last = mem_q[rd_idx_q][DATA_WIDTH];
        head_data = mem_q[rd_idx_q][DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/sram_pingpong_ctrl.sv
// Ping-pong controller for a 256x32 dual-port SRAM: producer fills one
// 128-word bank while the consumer drains the other.
//
// Bank states (one FSM per bank):
//   state    | meaning
//   EMPTY    | free; next write accepted latches the block length
//   FILLING  | producer writing, more words expected
//   FULL     | block complete, no read issued yet
//   DRAINING | reads issuing; returns to EMPTY after the last read issues
module sram_pingpong_ctrl
    import sram_pp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DW,
    parameter int unsigned ADDR_WIDTH = SRAM_AW,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_wadr,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_re,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic [3:0]            bank_st
);

    bank_state_e           state_q [2];
    bank_state_e           state_d [2];
    logic [ADDR_WIDTH-1:0] len_q [2];
    logic                  init_q;
    logic                  wr_bank_q;
    logic                  rd_bank_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [ADDR_WIDTH-1:0] wr_len;
    logic                  wr_last;
    logic                  rd_last_issue;
    logic                  wr_accept;
    logic                  rd_issue;
    logic                  pop;
    logic [2:0]            slots;
    logic                  rd_space;

    logic [1:0]            fifo_cnt;
    logic                  fifo_last;
    logic [DATA_WIDTH-1:0] fifo_data;

    // Length of the block being written comes from cfg_len only while the bank is still EMPTY.
    always_comb begin
        wr_len        = (state_q[wr_bank_q] == EMPTY) ? clamp_len(cfg_len) : len_q[wr_bank_q];
        wr_last       = ({1'b0, wr_ptr_q} == wr_len - ADDR_WIDTH'(1));
        rd_last_issue = ({1'b0, rd_ptr_q} == len_q[rd_bank_q] - ADDR_WIDTH'(1));
        pop           = rd_valid && rd_ready;
        slots         = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
        rd_space      = (slots < 3'(FIFO_DEPTH));
    end

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    // Next-state logic; a bank can only be a write target or a read target, never both.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                EMPTY: begin
                    if (wr_accept && wr_bank_q == 1'(b)) begin
                        state_d[b] = wr_last ? FULL : FILLING;
                    end
                end
                FILLING: begin
                    if (wr_accept && wr_bank_q == 1'(b) && wr_last) begin
                        state_d[b] = FULL;
                    end
                end
                FULL: begin
                    if (rd_issue && rd_bank_q == 1'(b)) begin
                        state_d[b] = rd_last_issue ? EMPTY : DRAINING;
                    end
                end
                DRAINING: begin
                    if (rd_issue && rd_bank_q == 1'(b) && rd_last_issue) begin
                        state_d[b] = EMPTY;
                    end
                end
                default: state_d[b] = EMPTY;
            endcase
        end
    end

    // Handshake and SRAM control outputs decoded from current state.
    always_comb begin
        wr_ready  = init_q && (state_q[wr_bank_q] == EMPTY || state_q[wr_bank_q] == FILLING);
        wr_accept = wr_valid && wr_ready;
        rd_issue  = (state_q[rd_bank_q] == FULL || state_q[rd_bank_q] == DRAINING) && rd_space;
        sram_we   = wr_accept;
        sram_wadr = {wr_bank_q, wr_ptr_q};
        sram_d    = wr_data;
        sram_re   = rd_issue;
        sram_radr = {rd_bank_q, rd_ptr_q};
        rd_valid  = (fifo_cnt != 2'd0);
        rd_data   = fifo_data;
        rd_last   = rd_valid && fifo_last;
        bank_st   = {state_q[1], state_q[0]};
    end

    // Init flag, pointers, bank selects, latched lengths and the read in-flight marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q          <= 1'b0;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            len_q[0]        <= '0;
            len_q[1]        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            init_q          <= 1'b1;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && rd_last_issue;
            if (wr_accept) begin
                if (state_q[wr_bank_q] == EMPTY) begin
                    len_q[wr_bank_q] <= wr_len;
                end
                if (wr_last) begin
                    wr_ptr_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
            end
            if (rd_issue) begin
                if (rd_last_issue) begin
                    rd_ptr_q  <= '0;
                    rd_bank_q <= ~rd_bank_q;
                end else begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    sram_pp_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_last (inflight_last_q),
        .push_data (sram_q),
        .pop       (pop),
        .cnt       (fifo_cnt),
        .head_last (fifo_last),
        .head_data (fifo_data)
    );

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Scoreboard bench for sram_pingpong_ctrl with a behavioural 256x32 SRAM.
module tb_sram_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        sram_we;
    logic [7:0]  sram_wadr;
    logic [31:0] sram_d;
    logic        sram_re;
    logic [7:0]  sram_radr;
    logic [31:0] sram_q;
    logic [3:0]  bank_st;

    always #5 clk = ~clk;

    sram_pingpong_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .sram_we   (sram_we),
        .sram_wadr (sram_wadr),
        .sram_d    (sram_d),
        .sram_re   (sram_re),
        .sram_radr (sram_radr),
        .sram_q    (sram_q),
        .bank_st   (bank_st)
    );

    logic [31:0] sram_mem [256];

    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_wadr] <= sram_d;
        if (sram_re) sram_q <= sram_mem[sram_radr];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          outstanding = 0;
    int          max_out = 0;
    int          n_pops  = 0;
    int          first_re = -1;
    int          first_rv = -1;
    logic        wbank;
    logic [32:0] sb_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Read-side monitor: pops the scoreboard on every consumer transfer.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (sram_re) begin
                outstanding++;
                if (first_re < 0) first_re = cyc;
            end
            if (rd_valid && first_rv < 0) first_rv = cyc;
            if (rd_valid && rd_ready) begin
                outstanding--;
                n_pops++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e[31:0]));
                    chk("rd_last", 64'(rd_last), 64'(e[32]));
                end
            end
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    // Writes one block; each accepted word is checked on the SRAM write port and queued.
    task automatic write_block(input int n, input logic [31:0] base, input int chg_len);
        for (int i = 0; i < n; i++) begin
            int          k;
            logic [32:0] ent;
            k        = 0;
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            @(negedge clk);
            while (!wr_ready && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (!wr_ready) begin
                chk("wr_timeout", 64'd0, 64'd1);
                wr_valid = 1'b0;
                return;
            end
            chk("wadr", 64'(sram_wadr), 64'({wbank, 7'(i)}));
            chk("we", 64'(sram_we), 64'd1);
            chk("wdata", 64'(sram_d), 64'(base + 32'(i)));
            ent = {(i == n - 1), base + 32'(i)};
            sb_q.push_back(ent);
            @(posedge clk);
            #1;
            if (i == 0 && chg_len >= 0) cfg_len = 8'(chg_len);
        end
        wr_valid = 1'b0;
        wbank    = ~wbank;
    endtask

    // Drains until the scoreboard is empty; mode 1 toggles rd_ready 1,0,0,...
    task automatic drain_wait(input int mode, input int maxc);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < maxc) begin
            rd_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_done", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        wbank = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int k;
        rst_n    = 1'b0;
        cfg_len  = 8'd0;
        wr_valid = 1'b0;
        wr_data  = 32'd0;
        rd_ready = 1'b0;
        wbank    = 1'b0;

        // 1: reset and init flag
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_bank_st", 64'(bank_st), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_wr_ready0", 64'(wr_ready), 64'd0);
        chk("init_bank_st", 64'(bank_st), 64'd0);
        chk("init_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("init_wr_ready1", 64'(wr_ready), 64'd1);
        chk("init_rd_valid1", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;

        // 2: single 4-word block, read latency
        cfg_len  = 8'd4;
        rd_ready = 1'b1;
        first_re = -1;
        first_rv = -1;
        write_block(4, 32'hA0, -1);
        chk("t2_bank0_full", 64'(bank_st), 64'h2);
        drain_wait(0, 200);
        chk("t2_latency", 64'(first_rv - first_re), 64'd2);

        // 3: both banks fill with consumer stalled, third block waits for bank0
        reset_dut();
        cfg_len = 8'd4;
        write_block(4, 32'h100, -1);
        write_block(4, 32'h110, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_wr_blocked", 64'(wr_ready), 64'd0);
        chk("t3_bank_st", 64'(bank_st), 64'hB);
        chk("t3_fifo_hold", 64'(rd_valid), 64'd1);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        write_block(4, 32'h120, -1);
        drain_wait(0, 300);

        // 4: 128-word block (cfg_len saturates), stalling consumer
        cfg_len  = 8'd200;
        rd_ready = 1'b0;
        write_block(128, 32'h1000, -1);
        drain_wait(1, 2000);

        // 5: cfg_len=0 gives 128 words; a mid-block cfg_len change is ignored
        cfg_len  = 8'd0;
        rd_ready = 1'b1;
        write_block(128, 32'h2000, 3);
        @(negedge clk);
        chk("t5_next_wadr", 64'(sram_wadr), 64'h80);
        @(posedge clk);
        #1;
        drain_wait(0, 500);

        // 6: reset mid-drain, then a fresh 2-word block
        cfg_len  = 8'd8;
        rd_ready = 1'b1;
        p0       = n_pops;
        write_block(8, 32'h3000, -1);
        k = 0;
        while (n_pops < p0 + 3 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t6_mid_drain", 64'(n_pops >= p0 + 3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("t6_rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("t6_rst_bank_st", 64'(bank_st), 64'd0);
        chk("t6_rst_sram_re", 64'(sram_re), 64'd0);
        sb_q.delete();
        wbank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cfg_len = 8'd2;
        write_block(2, 32'h4000, -1);
        drain_wait(0, 100);

        chk("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
